// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, ALU and select encodings for the multicycle RV32I controller.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNC = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLT = 3'b101, ALU_OR = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b010, ALU_XOR = 3'b110, ALU_SRL = 3'b111;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic       ADR_PC = 1'b0, ADR_RESULT = 1'b1;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
    localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps ALUOp and instruction function fields to ALUControl, flagging unsupported functions.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       illegal
);
    logic [2:0] func_ctrl;
    always_comb begin
        func_ctrl = ALU_ADD;
        case (func3)
            3'b000:  func_ctrl = (op5 && func7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  func_ctrl = ALU_SLT;
            3'b100:  func_ctrl = ALU_XOR;
            3'b101:  func_ctrl = ALU_SRL;
            3'b110:  func_ctrl = ALU_OR;
            3'b111:  func_ctrl = ALU_AND;
            default: func_ctrl = ALU_ADD;
        endcase
    end
    assign alu_control = (alu_op == ALUOP_FUNC) ? func_ctrl :
                         (alu_op == ALUOP_SUB)  ? ALU_SUB : ALU_ADD;
    assign illegal = (alu_op == ALUOP_FUNC) &&
                     (func3 == 3'b001 || func3 == 3'b011 || (func3 == 3'b101 && func7_5));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore-style FSM sequencing the shared RV32I datapath,
// with memory wait states, a sticky illegal-instruction trap and a retired-instruction counter.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);
    state_t     state, state_nxt, decode_nxt;
    logic [1:0] alu_op;
    logic       illegal, pc_w, mem_w, ir_w, reg_w, retire;
    mc_alu_decoder u_alu_dec (
        .alu_op(alu_op), .func3(func3), .func7_5(func7_5), .op5(opcode[5]),
        .alu_control(ALUControl), .illegal(illegal)
    );
    assign decode_nxt = (opcode == OP_LW || opcode == OP_SW)         ? S_MEMADR   :
                        (opcode == OP_RTYPE)                         ? S_EXECUTER :
                        (opcode == OP_ITYPE)                         ? S_EXECUTEI :
                        (opcode == OP_BRANCH && func3[2:1] == 2'b00) ? S_BRANCH   :
                        (opcode == OP_JAL)                           ? S_JAL      : S_TRAP;
    always_comb begin
        state_nxt = state;
        alu_op    = ALUOP_ADD;
        pc_w      = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        retire    = 1'b0;
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_w      = mem_ready;
                pc_w      = mem_ready;
                state_nxt = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                state_nxt = decode_nxt;
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc    = ADR_RESULT;
                state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = ADR_RESULT;
                mem_w     = 1'b1;
                retire    = mem_ready;
                state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_WD;
                alu_op    = ALUOP_FUNC;
                state_nxt = illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                reg_w     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                pc_w      = func3[0] ? ~zero : zero;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_w      = 1'b1;
                state_nxt = S_ALUWB;
            end
            default: state_nxt = S_TRAP;
        endcase
    end
    // FETCH strobes follow mem_ready, so they must be masked while reset is held
    assign PCWrite  = pc_w & rst;
    assign MemWrite = mem_w & rst;
    assign IRWrite  = ir_w & rst;
    assign RegWrite = reg_w & rst;
    assign trap     = (state == S_TRAP);
    assign ImmSrc   = (opcode == OP_SW)     ? IMM_S :
                      (opcode == OP_BRANCH) ? IMM_B :
                      (opcode == OP_JAL)    ? IMM_J : IMM_I;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: builds each instruction's expected per-cycle strobe trace from its class
// and memory wait counts, drives it with random wait states, and tracks retirement and trap behaviour.
module tb_multicycle_controller;
    localparam int CW = 4;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    logic clk = 1'b0, rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic func7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [CW-1:0] instret;
    int total = 0, bad = 0, model_cnt = 0;
    typedef struct {
        logic [3:0] strb;
        logic       mr;
        int         alu;
        int         res;
    } cyc_t;
    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .trap(trap), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -1 marks a function the ALU cannot perform
    function automatic int alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 1 : 0;
            3'd2:    return 5;
            3'd4:    return 6;
            3'd5:    return f7 ? -1 : 7;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int imm_exp(input logic [6:0] op);
        return (op == SW) ? 1 : (op == BR) ? 2 : (op == JL) ? 3 : 0;
    endfunction

    task automatic push(input logic [3:0] s, input logic mr, input int alu = -1, input int res = -1);
        cyc_t c;
        c.strb = s; c.mr = mr; c.alu = alu; c.res = res;
        q.push_back(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_srcb", 32'(ALUSrcB), 32'd2);
        chk("rst_res", 32'(ResultSrc), 32'd2);
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int dw);
        int a;
        bit retire = 0, trapped = 0;
        q.delete();
        a = alu_exp(f3, f7, op == RT);
        repeat (fw) push(4'b0000, 1'b0);
        push(4'b1010, 1'b1, 0, 2);
        push(4'b0000, 1'($urandom_range(1)), 0);
        if (op == LW) begin
            push(4'b0000, 1'($urandom_range(1)), 0);
            repeat (dw) push(4'b0000, 1'b0, -1, 0);
            push(4'b0000, 1'b1, -1, 0);
            push(4'b0001, 1'($urandom_range(1)), -1, 1);
            retire = 1;
        end else if (op == SW) begin
            push(4'b0000, 1'($urandom_range(1)), 0);
            repeat (dw) push(4'b0100, 1'b0, -1, 0);
            push(4'b0100, 1'b1, -1, 0);
            retire = 1;
        end else if (op == RT || op == IT) begin
            push(4'b0000, 1'($urandom_range(1)), a);
            if (a < 0) trapped = 1;
            else begin
                push(4'b0001, 1'($urandom_range(1)), -1, 0);
                retire = 1;
            end
        end else if (op == BR && f3[2:1] == 2'b00) begin
            push({(f3[0] ? !z : z), 3'b000}, 1'($urandom_range(1)), 1, 0);
            retire = 1;
        end else if (op == JL) begin
            push(4'b1000, 1'($urandom_range(1)), 0, 0);
            push(4'b0001, 1'($urandom_range(1)), -1, 0);
            retire = 1;
        end else trapped = 1;
        foreach (q[i]) begin
            @(negedge clk);
            opcode = op; func3 = f3; func7_5 = f7; zero = z; mem_ready = q[i].mr;
            #1;
            chk("strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'(q[i].strb));
            chk("immsrc", 32'(ImmSrc), 32'(imm_exp(op)));
            if (q[i].alu >= 0) chk("aluctl", 32'(ALUControl), 32'(q[i].alu));
            if (q[i].res >= 0) chk("resultsrc", 32'(ResultSrc), 32'(q[i].res));
        end
        if (trapped) begin
            repeat (4) begin
                @(negedge clk);
                mem_ready = 1'($urandom_range(1));
                #1;
                chk("trap_flag", 32'(trap), 32'd1);
                chk("trap_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
                chk("trap_instret", 32'(instret), 32'(model_cnt));
            end
            do_reset();
        end else begin
            model_cnt = (model_cnt + int'(retire)) % (1 << CW);
            @(posedge clk);
            #1;
            chk("instret", 32'(instret), 32'(model_cnt));
            chk("no_trap", 32'(trap), 32'd0);
        end
    endtask

    initial begin
        logic [6:0] op;
        int k;
        mem_ready = 1'b1;
        #3;
        chk("init_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
        chk("init_instret", 32'(instret), 32'd0);
        chk("init_trap", 32'(trap), 32'd0);
        do_reset();
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 2);
        run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0);
        run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
        run_instr(BR, 3'b000, 1'b0, 1'b1, 1, 0);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        // reset during a stalled store write
        @(negedge clk); opcode = SW; func3 = 3'b010; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("sw_pre_rst", 32'(MemWrite), 32'd1);
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("sw_rst_irwrite", 32'(IRWrite), 32'd0);
        chk("sw_rst_adrsrc", 32'(AdrSrc), 32'd0);
        chk("sw_rst_instret", 32'(instret), 32'd0);
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        run_instr(IT, 3'b101, 1'b1, 1'b0, 0, 0);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 19);
            op = (k < 4) ? LW : (k < 7) ? SW : (k < 11) ? RT : (k < 14) ? IT :
                 (k < 17) ? BR : (k < 19) ? JL : 7'($urandom);
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style main controller that sequences the shared RV32I datapath over several cycles, one architectural instruction at a time.
- One ALU and one unified instruction/data memory port are reused across states.
- Drives every mux select and write strobe of the datapath, handles memory wait states through mem_ready, and retires an instruction count.
- Sits beside the register file, ALU and memory; decodes only opcode/func3/func7_5 fields supplied by the instruction register.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7_5  in  1  IR[30]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  out  2  00=WriteData register, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 101 slt, 011 or, 010 and, 110 xor, 111 srl
- trap  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst; the port names clk and rst are fixed.
- Reset state and outputs:
  - While rst=0: state=FETCH, trap=0, instret=0.
  - All write strobes (PCWrite, MemWrite, IRWrite, RegWrite) are forced 0.
  - Selects take their FETCH values.
- Reset mid-instruction aborts the instruction; it is not counted.
- Outputs are combinational from state, plus the decoded fields, zero and mem_ready. Unlisted selects are 00; unlisted strobes are 0.
- ImmSrc by opcode in every state: sw=01, branch=10, jal=11, otherwise 00.
- ALUOp (internal): 00=add, 01=sub, 10=function-decoded.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready, otherwise holds.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target to ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 with func3 000/001 -> BRANCH
    - 1101111 -> JAL
    - anything else -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready. Goes to FETCH on the mem_ready cycle.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = func3[0] ? ~zero : zero. Goes to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
  - TRAP: no strobes. trap=1 and stays until reset.
- Function decode (ALUOp=10), by func3:
  - 000: add; sub only for R-type with func7_5=1.
  - 010: slt
  - 100: xor
  - 101: srl, only if func7_5=0
  - 110: or
  - 111: and
- Illegal function: func3 001/011, or func3 101 with func7_5=1. In EXECUTER/EXECUTEI this sends the FSM to TRAP instead of ALUWB, with RegWrite=0.
- instret counting:
  - Increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready.
  - JAL counts once, at its ALUWB.
  - Wraps modulo 2^CNT_W.
- Latencies with mem_ready tied 1, in cycles:
  - lw: 5
  - sw: 4
  - R/I: 4
  - branch: 3
  - jal: 4

Decomposition:
- Shared package mc_pkg holds:
  - state enum (4-bit, 12 states)
  - ALUOp codes
  - ALUControl codes matching the existing ALU
  - opcode constants: LW, SW, RTYPE, ITYPE, BRANCH, JAL
  - select encodings for AdrSrc, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc
- One sub-module, mc_alu_decoder: combinational (ALUOp, func3, func7_5, opcode[5]) -> ALUControl and an illegal flag.

Test Plan:
- Reset release, then add x3,x1,x2 with mem_ready=1 -> FETCH, DECODE, EXECUTER, ALUWB. ALUControl=000 in EXECUTER, RegWrite=1 only in ALUWB, instret=1.
- lw with mem_ready low for 3 cycles in MEMREAD -> state holds 3 cycles with no strobes. MEMWB follows with ResultSrc=01 and RegWrite=1; total 8 cycles.
- sw with mem_ready delayed 2 cycles -> MemWrite=1 for exactly 3 cycles, then FETCH. RegWrite never 1.
- bne (func3=001) with zero=0, then zero=1 -> PCWrite=1 in BRANCH only in the first case. ALUControl=001; instret +1 each.
- sub, srai, opcode 0000000 -> sub gives ALUControl=001. srai (func3=101, func7_5=1) and opcode 0000000 both raise trap=1, strobes stay 0, and FETCH is never reached until rst pulses low.
- rst asserted low during MEMWRITE -> MemWrite drops to 0 immediately (asynchronously), state=FETCH, instret unchanged from pre-instruction value reset to 0.
